hdmi_in_ddr_wr: RTL and testbench

Capture-side counterpart of the HDMI output path: accepts 24-bit RGB pixels with DE/VS in the pixel-clock domain and packs 10 pixels into one 240-bit word. Words cross to ddr_clk through the PIX_BUFF asynchronous FIFO and are written to DDR as single-beat writes at consecutive 32-byte addresses. The frame buffer read by the output path is filled by this block.

---
 rtl/hdmi_in_ddr_wr_pkg.sv | 38 +++
 rtl/hdmi_in_ddr_wr_if.sv | 22 ++
 rtl/hdmi_in_ddr_wr_pix_buff.sv | 99 +++++++++
 rtl/hdmi_in_ddr_wr_pix_pack10.sv | 70 +++++++
 rtl/hdmi_in_ddr_wr.sv | 132 +++++++++++++
 tb/tb_hdmi_in_ddr_wr.sv | 273 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/hdmi_in_ddr_wr_pkg.sv
// Shared widths, encodings and helpers for the HDMI capture-to-DDR write path.
package hdmi_in_ddr_wr_pkg;

  localparam int unsigned CTRL_ADDR_WIDTH = 28;
  localparam int unsigned MEM_DQ_WIDTH    = 32;
  localparam int unsigned DDR_DATA_WIDTH  = MEM_DQ_WIDTH * 8;
  localparam int unsigned PIXS_WIDTH      = 240;
  localparam int unsigned PIX_WIDTH       = 24;
  localparam int unsigned PIX_PER_WORD    = PIXS_WIDTH / PIX_WIDTH;
  localparam int unsigned PIX_CNT_WIDTH   = 4;
  localparam int unsigned FIFO_ADDR_WIDTH = 3;
  localparam int unsigned STATE_WIDTH     = 4;
  localparam int unsigned AWLEN_WIDTH     = 4;

  // Last 32-byte aligned location of the frame buffer
  localparam logic [CTRL_ADDR_WIDTH-1:0] MAX_MEM_LOC = CTRL_ADDR_WIDTH'(28'h0FF_FFE0);

  // One-hot write FSM states; the encoding is also what drives the LEDs
  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE    = 4'b0001,
    ST_FIFO_RD = 4'b0010,
    ST_LATCH   = 4'b0100,
    ST_DDR_WR  = 4'b1000
  } wr_state_e;

  // Incoming pixel, red in the top byte
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Binary to Gray conversion for the FIFO pointers
  function automatic logic [FIFO_ADDR_WIDTH:0] bin2gray(input logic [FIFO_ADDR_WIDTH:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/hdmi_in_ddr_wr_if.sv
// DDR controller write port: single-beat request/acknowledge handshake.
interface hdmi_in_ddr_wr_if;
  import hdmi_in_ddr_wr_pkg::*;

  logic                       wr_req;
  logic                       wr_ack;
  logic                       ddr_wbusy;
  logic [CTRL_ADDR_WIDTH-1:0] ddr_wr_adr;
  logic [AWLEN_WIDTH-1:0]     awlen;
  logic [DDR_DATA_WIDTH-1:0]  ddr_wdata;

  modport master (
    output wr_req, ddr_wr_adr, awlen, ddr_wdata,
    input  wr_ack, ddr_wbusy
  );

  modport slave (
    input  wr_req, ddr_wr_adr, awlen, ddr_wdata,
    output wr_ack, ddr_wbusy
  );

endinterface

// File: rtl/hdmi_in_ddr_wr_pix_buff.sv
// PIX_BUFF: 240-bit asynchronous FIFO, Gray-coded pointers with two-flop
// synchronisers, registered read data one cycle after rd_en.
module hdmi_in_ddr_wr_pix_buff
  import hdmi_in_ddr_wr_pkg::*;
(
  input  logic                  wr_clk,
  input  logic                  i_wr_rst,
  input  logic                  i_wr_en,
  input  logic [PIXS_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_full_c,
  input  logic                  rd_clk,
  input  logic                  i_rd_rst,
  input  logic                  i_rd_en,
  output logic [PIXS_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_empty_c
);

  localparam int unsigned PTR_W = FIFO_ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << FIFO_ADDR_WIDTH;

  logic [PIXS_WIDTH-1:0] r_mem [DEPTH];

  logic [PTR_W-1:0]      r_wr_bin;
  logic [PTR_W-1:0]      r_wr_gray;
  logic [PTR_W-1:0]      r_rd_gray_s1;
  logic [PTR_W-1:0]      r_rd_gray_s2;
  logic [PTR_W-1:0]      r_rd_bin;
  logic [PTR_W-1:0]      r_rd_gray;
  logic [PTR_W-1:0]      r_wr_gray_s1;
  logic [PTR_W-1:0]      r_wr_gray_s2;
  logic [PIXS_WIDTH-1:0] r_rd_data;

  logic [PTR_W-1:0]      w_wr_bin_nxt;
  logic [PTR_W-1:0]      w_rd_bin_nxt;
  logic                  w_wr_full;
  logic                  w_rd_empty;
  logic                  w_wr_go;
  logic                  w_rd_go;

  assign w_wr_bin_nxt = r_wr_bin + PTR_W'(1);
  assign w_rd_bin_nxt = r_rd_bin + PTR_W'(1);
  assign w_wr_full    = (r_wr_gray == {~r_rd_gray_s2[PTR_W-1:PTR_W-2], r_rd_gray_s2[PTR_W-3:0]});
  assign w_rd_empty   = (r_rd_gray == r_wr_gray_s2);
  assign w_wr_go      = i_wr_en & ~w_wr_full;
  assign w_rd_go      = i_rd_en & ~w_rd_empty;

  // Write pointer and read-pointer synchroniser
  always_ff @(posedge wr_clk) begin
    if (i_wr_rst) begin
      r_wr_bin     <= '0;
      r_wr_gray    <= '0;
      r_rd_gray_s1 <= '0;
      r_rd_gray_s2 <= '0;
    end else begin
      r_rd_gray_s1 <= r_rd_gray;
      r_rd_gray_s2 <= r_rd_gray_s1;
      if (w_wr_go) begin
        r_wr_bin  <= w_wr_bin_nxt;
        r_wr_gray <= bin2gray(w_wr_bin_nxt);
      end
    end
  end

  // Storage array
  always_ff @(posedge wr_clk) begin
    if (w_wr_go) begin
      r_mem[r_wr_bin[FIFO_ADDR_WIDTH-1:0]] <= i_wr_data;
    end
  end

  // Read pointer and write-pointer synchroniser
  always_ff @(posedge rd_clk) begin
    if (i_rd_rst) begin
      r_rd_bin     <= '0;
      r_rd_gray    <= '0;
      r_wr_gray_s1 <= '0;
      r_wr_gray_s2 <= '0;
    end else begin
      r_wr_gray_s1 <= r_wr_gray;
      r_wr_gray_s2 <= r_wr_gray_s1;
      if (w_rd_go) begin
        r_rd_bin  <= w_rd_bin_nxt;
        r_rd_gray <= bin2gray(w_rd_bin_nxt);
      end
    end
  end

  // Registered read data
  always_ff @(posedge rd_clk) begin
    if (w_rd_go) begin
      r_rd_data <= r_mem[r_rd_bin[FIFO_ADDR_WIDTH-1:0]];
    end
  end

  assign o_wr_full_c  = w_wr_full;
  assign o_rd_empty_c = w_rd_empty;
  assign o_rd_data    = r_rd_data;

endmodule

// File: rtl/hdmi_in_ddr_wr_pix_pack10.sv
// Pixel-domain packer: gathers 10 RGB pixels into one 240-bit word, first pixel
// in the top slot. A rising VS throws away any partial word. A full word that
// meets a full FIFO is dropped and flagged in a sticky overflow bit.
module hdmi_in_ddr_wr_pix_pack10
  import hdmi_in_ddr_wr_pkg::*;
(
  input  logic                  pix_clk,
  input  logic                  rstn,
  input  logic                  i_vs_in,
  input  logic                  i_de_in,
  input  rgb_t                  i_rgb_in,
  input  logic                  i_wr_full,
  output logic                  o_wr_en,
  output logic [PIXS_WIDTH-1:0] o_wr_data,
  output logic                  o_overflow
);

  localparam int unsigned SLOT_IDX_WIDTH = $clog2(PIXS_WIDTH);

  logic [PIX_CNT_WIDTH-1:0]  r_pix_cnt;
  logic [PIXS_WIDTH-1:0]     r_word;
  logic                      r_vs_d;
  logic                      r_wr_en;
  logic [PIXS_WIDTH-1:0]     r_wr_data;
  logic                      r_overflow;

  logic                      w_vs_rise;
  logic                      w_last;
  logic [SLOT_IDX_WIDTH-1:0] w_slot_lsb;

  assign w_vs_rise  = i_vs_in & ~r_vs_d;
  assign w_last     = i_de_in && (r_pix_cnt == PIX_CNT_WIDTH'(PIX_PER_WORD - 1));
  assign w_slot_lsb = SLOT_IDX_WIDTH'(PIXS_WIDTH - PIX_WIDTH - PIX_WIDTH * 32'(r_pix_cnt));

  // Slot fill, word push on the tenth pixel, VS discard and overflow flag
  always_ff @(posedge pix_clk) begin
    if (!rstn) begin
      r_pix_cnt  <= '0;
      r_word     <= '0;
      r_vs_d     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_vs_d  <= i_vs_in;
      r_wr_en <= 1'b0;
      if (w_vs_rise) begin
        r_pix_cnt <= '0;
        r_word    <= '0;
      end else if (w_last) begin
        r_pix_cnt <= '0;
        r_word    <= '0;
        if (i_wr_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_wr_en   <= 1'b1;
          r_wr_data <= {r_word[PIXS_WIDTH-1:PIX_WIDTH], i_rgb_in};
        end
      end else if (i_de_in) begin
        r_word[w_slot_lsb +: PIX_WIDTH] <= i_rgb_in;
        r_pix_cnt                       <= r_pix_cnt + PIX_CNT_WIDTH'(1);
      end
    end
  end

  assign o_wr_en    = r_wr_en;
  assign o_wr_data  = r_wr_data;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/hdmi_in_ddr_wr.sv
// HDMI capture write path: packs pixels into 240-bit words, moves them to the
// DDR clock through PIX_BUFF and writes them as single beats at consecutive
// 32-byte addresses. A new frame restarts the address at 0.
module hdmi_in_ddr_wr
  import hdmi_in_ddr_wr_pkg::*;
#(
  parameter logic [CTRL_ADDR_WIDTH-1:0] MAX_ADR  = MAX_MEM_LOC,
  parameter int unsigned                ADR_STEP = 32
) (
  input  logic                   ddr_clk,
  input  logic                   rstn,
  input  logic                   pix_clk,
  input  logic                   i_init_done,
  input  logic                   i_vs_in,
  input  logic                   i_de_in,
  input  rgb_t                   i_rgb_in,
  hdmi_in_ddr_wr_if.master       ddr,
  output logic                   o_overflow,
  output logic [STATE_WIDTH-1:0] o_led
);

  wr_state_e                  r_state;
  logic                       r_rd_en;
  logic                       r_wr_req;
  logic [CTRL_ADDR_WIDTH-1:0] r_adr;
  logic [DDR_DATA_WIDTH-1:0]  r_wdata;
  logic                       r_frame_pend;
  logic [2:0]                 r_vs_sync;

  logic                       w_wr_en;
  logic [PIXS_WIDTH-1:0]      w_wr_data;
  logic                       w_wr_full;
  logic                       w_rd_empty;
  logic [PIXS_WIDTH-1:0]      w_rd_data;
  logic                       w_wr_rst;
  logic                       w_rd_rst;
  logic                       w_vs_rise;

  // The read side is also held in reset until DDR calibration completes
  assign w_wr_rst  = ~rstn;
  assign w_rd_rst  = ~rstn | ~i_init_done;
  assign w_vs_rise = r_vs_sync[1] & ~r_vs_sync[2];

  hdmi_in_ddr_wr_pix_pack10 u_pack (
    .pix_clk    (pix_clk),
    .rstn       (rstn),
    .i_vs_in    (i_vs_in),
    .i_de_in    (i_de_in),
    .i_rgb_in   (i_rgb_in),
    .i_wr_full  (w_wr_full),
    .o_wr_en    (w_wr_en),
    .o_wr_data  (w_wr_data),
    .o_overflow (o_overflow)
  );

  hdmi_in_ddr_wr_pix_buff u_pix_buff (
    .wr_clk       (pix_clk),
    .i_wr_rst     (w_wr_rst),
    .i_wr_en      (w_wr_en),
    .i_wr_data    (w_wr_data),
    .o_wr_full_c  (w_wr_full),
    .rd_clk       (ddr_clk),
    .i_rd_rst     (w_rd_rst),
    .i_rd_en      (r_rd_en),
    .o_rd_data    (w_rd_data),
    .o_rd_empty_c (w_rd_empty)
  );

  // Two-flop VS synchroniser plus one stage for edge detection
  always_ff @(posedge ddr_clk) begin
    if (!rstn) begin
      r_vs_sync <= '0;
    end else begin
      r_vs_sync <= {r_vs_sync[1:0], i_vs_in};
    end
  end

  // Write FSM: fetch one FIFO word, present it to DDR, advance the address on ack
  always_ff @(posedge ddr_clk) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_rd_en      <= 1'b0;
      r_wr_req     <= 1'b0;
      r_adr        <= '0;
      r_wdata      <= '0;
      r_frame_pend <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_frame_pend) begin
            r_adr        <= '0;
            r_frame_pend <= 1'b0;
          end else if (i_init_done && !w_rd_empty && !ddr.ddr_wbusy) begin
            r_rd_en <= 1'b1;
            r_state <= ST_FIFO_RD;
          end
        end
        ST_FIFO_RD: begin
          r_state <= ST_LATCH;
        end
        ST_LATCH: begin
          r_wdata  <= DDR_DATA_WIDTH'(w_rd_data);
          r_wr_req <= 1'b1;
          r_state  <= ST_DDR_WR;
        end
        ST_DDR_WR: begin
          if (ddr.wr_ack) begin
            r_wr_req <= 1'b0;
            r_adr    <= (r_adr == MAX_ADR) ? '0 : r_adr + CTRL_ADDR_WIDTH'(ADR_STEP);
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_wr_req <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
      // A new frame waits here until the FSM is back in IDLE
      if (w_vs_rise) begin
        r_frame_pend <= 1'b1;
      end
    end
  end

  assign ddr.wr_req     = r_wr_req;
  assign ddr.ddr_wr_adr = r_adr;
  assign ddr.awlen      = '0;
  assign ddr.ddr_wdata  = r_wdata;
  assign o_led          = r_state;

endmodule

// File: tb/tb_hdmi_in_ddr_wr.sv
// Scoreboard bench: pixel tasks model the expected 240-bit words and their
// addresses; a DDR responder acks each request and checks it against the queue.
module tb_hdmi_in_ddr_wr;
  import hdmi_in_ddr_wr_pkg::*;

  localparam logic [CTRL_ADDR_WIDTH-1:0] TB_MAX_ADR = CTRL_ADDR_WIDTH'(96);
  localparam int unsigned TB_STEP       = 32;
  localparam int unsigned TB_FIFO_DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int unsigned DRAIN_BUDGET  = 4000;

  typedef struct {
    logic [CTRL_ADDR_WIDTH-1:0] adr;
    logic [PIXS_WIDTH-1:0]      data;
  } exp_t;

  logic       ddr_clk   = 1'b0;
  logic       pix_clk   = 1'b0;
  logic       rstn      = 1'b0;
  logic       init_done = 1'b0;
  logic       vs_in     = 1'b0;
  logic       de_in     = 1'b0;
  rgb_t       rgb_in;
  logic       overflow;
  logic [3:0] led;

  hdmi_in_ddr_wr_if bus();

  hdmi_in_ddr_wr #(.MAX_ADR(TB_MAX_ADR), .ADR_STEP(TB_STEP)) dut (
    .ddr_clk     (ddr_clk),
    .rstn        (rstn),
    .pix_clk     (pix_clk),
    .i_init_done (init_done),
    .i_vs_in     (vs_in),
    .i_de_in     (de_in),
    .i_rgb_in    (rgb_in),
    .ddr         (bus),
    .o_overflow  (overflow),
    .o_led       (led)
  );

  always #5 ddr_clk = ~ddr_clk;
  always #7 pix_clk = ~pix_clk;

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];

  logic [PIXS_WIDTH-1:0]      m_word = '0;
  int                         m_cnt  = 0;
  logic [CTRL_ADDR_WIDTH-1:0] m_adr  = '0;
  bit                         m_hold = 1'b0;
  int                         m_held = 0;
  bit                         m_ovf  = 1'b0;
  bit                         m_discard = 1'b0;

  bit                        ack_en = 1'b1;
  int                        req_cycles = 0;
  int                        busy_req_cycles = 0;
  logic [DDR_DATA_WIDTH-1:0] last_wdata = '0;

  function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  task automatic send_pix(input logic [23:0] v);
    exp_t e;
    @(negedge pix_clk);
    de_in  = 1'b1;
    rgb_in = v;
    m_word = {m_word[PIXS_WIDTH-PIX_WIDTH-1:0], v};
    m_cnt++;
    if (m_cnt == 10) begin
      m_cnt = 0;
      if (!m_discard) begin
        if (m_hold && m_held >= int'(TB_FIFO_DEPTH)) begin
          m_ovf = 1'b1;
        end else begin
          e.adr  = m_adr;
          e.data = m_word;
          exp_q.push_back(e);
          m_adr = (m_adr == TB_MAX_ADR) ? '0 : m_adr + CTRL_ADDR_WIDTH'(TB_STEP);
          if (m_hold) m_held++;
        end
      end
    end
  endtask

  task automatic send_run(input logic [23:0] start, input int n);
    for (int i = 0; i < n; i++) send_pix(start + 24'(i));
    @(negedge pix_clk);
    de_in = 1'b0;
  endtask

  task automatic vs_pulse();
    @(negedge pix_clk);
    de_in = 1'b0;
    vs_in = 1'b1;
    repeat (3) @(negedge pix_clk);
    vs_in = 1'b0;
    m_cnt = 0;
    m_adr = '0;
    repeat (12) @(negedge ddr_clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || led != 4'b0001 || bus.wr_req) && n < int'(DRAIN_BUDGET)) begin
      @(negedge ddr_clk);
      n++;
    end
    if (n >= int'(DRAIN_BUDGET)) begin
      checks++;
      failures++;
      $display("FAIL %s_drain_timeout pending=%0d", name, exp_q.size());
    end
    repeat (6) @(negedge ddr_clk);
  endtask

  // DDR responder and monitor: ack two cycles into each request, check the beat
  initial begin : responder
    int   age;
    exp_t e;
    age = 0;
    bus.wr_ack = 1'b0;
    forever begin
      @(negedge ddr_clk);
      bus.wr_ack = 1'b0;
      if (bus.wr_req) req_cycles++;
      if (bus.wr_req && bus.ddr_wbusy) busy_req_cycles++;
      if (bus.wr_req && ack_en && rstn) begin
        if (age == 2) begin
          last_wdata = bus.ddr_wdata;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write adr=%h data=%h", bus.ddr_wr_adr, bus.ddr_wdata);
          end else begin
            e = exp_q.pop_front();
            check("wr_adr", 256'(bus.ddr_wr_adr), 256'(e.adr));
            check("wr_data", 256'(bus.ddr_wdata), 256'(e.data));
            check("awlen", 256'(bus.awlen), 256'(0));
          end
          bus.wr_ack = 1'b1;
          age = 0;
        end else begin
          age++;
        end
      end else begin
        age = 0;
      end
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "simulation did not terminate");
  end

  initial begin : main
    int snap;
    int n;
    bus.ddr_wbusy = 1'b0;
    rgb_in        = '0;
    init_done     = 1'b1;
    rstn          = 1'b0;
    repeat (6) @(negedge ddr_clk);
    check("rst_wr_req", 256'(bus.wr_req), 256'(0));
    check("rst_adr", 256'(bus.ddr_wr_adr), 256'(0));
    check("rst_awlen", 256'(bus.awlen), 256'(0));
    check("rst_wdata", 256'(bus.ddr_wdata), 256'(0));
    check("rst_overflow", 256'(overflow), 256'(0));
    check("rst_led", 256'(led), 256'(4'b0001));
    rstn = 1'b1;
    repeat (4) @(negedge ddr_clk);

    // Single word after reset
    send_run(24'h000001, 10);
    wait_drain("t1");
    check("t1_first_pixel", 256'(last_wdata[239:216]), 256'(24'h000001));
    check("t1_last_pixel", 256'(last_wdata[23:0]), 256'(24'h00000A));
    check("t1_pad", 256'(last_wdata[255:240]), 256'(0));
    check("t1_next_adr", 256'(bus.ddr_wr_adr), 256'(32));

    // New frame, three consecutive words at 0, 32, 64
    vs_pulse();
    send_run(24'h000100, 30);
    wait_drain("t2");
    check("t2_next_adr", 256'(bus.ddr_wr_adr), 256'(96));

    // Partial word discarded by VS, address restarts
    send_run(24'h000200, 7);
    vs_pulse();
    send_run(24'h000300, 10);
    wait_drain("t3");
    check("t3_next_adr", 256'(bus.ddr_wr_adr), 256'(32));

    // Address wraps after MAX_ADR
    send_run(24'h000400, 30);
    wait_drain("t4a");
    check("t4_wrap_adr", 256'(bus.ddr_wr_adr), 256'(0));
    send_run(24'h000450, 10);
    wait_drain("t4b");

    // Controller busy while more than a FIFO's worth streams in
    bus.ddr_wbusy   = 1'b1;
    m_hold          = 1'b1;
    m_held          = 0;
    busy_req_cycles = 0;
    send_run(24'h000500, 100);
    repeat (50) @(negedge ddr_clk);
    check("t5_no_req_busy", 256'(busy_req_cycles), 256'(0));
    check("t5_overflow", 256'(overflow), 256'(m_ovf));
    bus.ddr_wbusy = 1'b0;
    m_hold        = 1'b0;
    wait_drain("t5");
    check("t5_overflow_sticky", 256'(overflow), 256'(1));

    // Calibration not done: nothing is written
    init_done = 1'b0;
    m_discard = 1'b1;
    snap      = req_cycles;
    send_run(24'h000600, 20);
    repeat (40) @(negedge ddr_clk);
    check("t6_no_req_uncal", 256'(req_cycles - snap), 256'(0));
    rstn = 1'b0;
    repeat (6) @(negedge ddr_clk);
    check("t6_rst_overflow", 256'(overflow), 256'(0));
    check("t6_rst_adr", 256'(bus.ddr_wr_adr), 256'(0));
    check("t6_rst_led", 256'(led), 256'(4'b0001));
    rstn      = 1'b1;
    init_done = 1'b1;
    m_cnt     = 0;
    m_adr     = '0;
    m_ovf     = 1'b0;
    repeat (4) @(negedge ddr_clk);

    // Reset in the middle of a DDR write
    ack_en = 1'b0;
    send_run(24'h000700, 10);
    n = 0;
    while (!bus.wr_req && n < 1000) begin
      @(negedge ddr_clk);
      n++;
    end
    check("t7_req_up", 256'(bus.wr_req), 256'(1));
    rstn = 1'b0;
    @(negedge ddr_clk);
    check("t7_rst_wr_req", 256'(bus.wr_req), 256'(0));
    check("t7_rst_led", 256'(led), 256'(4'b0001));
    repeat (4) @(negedge ddr_clk);
    rstn      = 1'b1;
    ack_en    = 1'b1;
    m_discard = 1'b0;
    m_cnt     = 0;
    repeat (4) @(negedge ddr_clk);

    // Normal operation after the mid-transfer reset
    send_run(24'h000800, 10);
    wait_drain("t8");
    check("t8_next_adr", 256'(bus.ddr_wr_adr), 256'(32));
    check("end_queue_empty", 256'(exp_q.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
